// File: rtl/sig_debounce_evt.sv
// Debounces a synchronized level: a new value must hold HOLD_CYCLES cycles before it is
// accepted, producing a pulse, a single-slot valid/ready event and saturating counts.
module sig_debounce_evt #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_sig,
  input  logic                 evt_ready,
  input  logic                 ovf_clr,
  output logic                 stable_level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic                 evt_valid,
  output logic                 evt_type,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] evt_cnt,
  output logic [CNT_WIDTH-1:0] glitch_cnt
);

  localparam int unsigned HW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW:0] HOLD_L = (HW+1)'(HOLD_CYCLES);
  localparam logic [HW:0] ONE_L  = (HW+1)'(1);
  localparam bit          SINGLE = (HOLD_CYCLES == 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  state_t                 state_q;
  logic [HW-1:0]          hcnt_q;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;

  logic                   evt_valid_q, evt_valid_d;
  logic                   evt_type_q,  evt_type_d;
  logic                   ovf_q,       ovf_d;
  logic [CNT_WIDTH-1:0]   evt_cnt_q,   evt_cnt_d;
  logic [CNT_WIDTH-1:0]   glitch_cnt_q, glitch_cnt_d;

  logic                   hold_done;
  logic                   acc_rise;
  logic                   acc_fall;
  logic                   abort;
  logic                   post;

  // hcnt is widened by one bit so hcnt+1 cannot wrap when HOLD_CYCLES is a power of two minus one
  assign hold_done = (({1'b0, hcnt_q} + ONE_L) == HOLD_L);

  always_comb begin
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      S_LOW:      acc_rise = sync_sig && SINGLE;
      S_RISE_CHK: begin
        if (!sync_sig) abort    = 1'b1;
        else           acc_rise = hold_done;
      end
      S_HIGH:     acc_fall = !sync_sig && SINGLE;
      S_FALL_CHK: begin
        if (sync_sig) abort    = 1'b1;
        else          acc_fall = hold_done;
      end
      default: ;
    endcase
  end

  assign post = acc_rise || acc_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOW;
      hcnt_q   <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= acc_rise;
      fall_q <= acc_fall;
      unique case (state_q)
        S_LOW: begin
          if (acc_rise) begin
            state_q  <= S_HIGH;
            stable_q <= 1'b1;
          end else if (sync_sig) begin
            state_q <= S_RISE_CHK;
            hcnt_q  <= HW'(1);
          end
        end
        S_RISE_CHK: begin
          if (abort) begin
            state_q <= S_LOW;
            hcnt_q  <= '0;
          end else if (acc_rise) begin
            state_q  <= S_HIGH;
            hcnt_q   <= '0;
            stable_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        S_HIGH: begin
          if (acc_fall) begin
            state_q  <= S_LOW;
            stable_q <= 1'b0;
          end else if (!sync_sig) begin
            state_q <= S_FALL_CHK;
            hcnt_q  <= HW'(1);
          end
        end
        S_FALL_CHK: begin
          if (abort) begin
            state_q <= S_HIGH;
            hcnt_q  <= '0;
          end else if (acc_fall) begin
            state_q  <= S_LOW;
            hcnt_q   <= '0;
            stable_q <= 1'b0;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        default: begin
          state_q <= S_LOW;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    evt_cnt_d    = evt_cnt_q;
    glitch_cnt_d = glitch_cnt_q;
    evt_valid_d  = evt_valid_q;
    evt_type_d   = evt_type_q;
    ovf_d        = ovf_q;

    if (post && (evt_cnt_q != '1))
      evt_cnt_d = evt_cnt_q + CNT_WIDTH'(1);
    if (abort && (glitch_cnt_q != '1))
      glitch_cnt_d = glitch_cnt_q + CNT_WIDTH'(1);

    // A post always wins the slot; a simultaneous accept just consumes the old entry
    if (post) begin
      evt_valid_d = 1'b1;
      evt_type_d  = acc_rise;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (ovf_clr)
      ovf_d = 1'b0;
    if (post && evt_valid_q && !evt_ready)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q  <= 1'b0;
      evt_type_q   <= 1'b0;
      ovf_q        <= 1'b0;
      evt_cnt_q    <= '0;
      glitch_cnt_q <= '0;
    end else begin
      evt_valid_q  <= evt_valid_d;
      evt_type_q   <= evt_type_d;
      ovf_q        <= ovf_d;
      evt_cnt_q    <= evt_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign stable_level = stable_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign evt_valid    = evt_valid_q;
  assign evt_type     = evt_type_q;
  assign ovf          = ovf_q;
  assign evt_cnt      = evt_cnt_q;
  assign glitch_cnt   = glitch_cnt_q;

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rise_q && fall_q));
  a_pulse_one:  assert property (@(posedge clk) disable iff (!rst_n) rise_q |=> !rise_q);

endmodule

// File: tb/tb_sig_debounce_evt.sv
// Scoreboard bench for sig_debounce_evt: expected events are queued with the stimulus and
// popped by a negedge monitor whenever the DUT emits a rise or fall pulse.
module tb_sig_debounce_evt;

  logic        clk;
  logic        rst_n;
  logic        sync_sig, evt_ready, ovf_clr;
  logic        stable_level, rise_pulse, fall_pulse, evt_valid, evt_type, ovf;
  logic [15:0] evt_cnt, glitch_cnt;

  logic        sync2, ready2, ovf_clr2;
  logic        stable2, rise2, fall2, valid2, type2, ovf2;
  logic [1:0]  cnt2, gl2;

  int          n_pass  = 0;
  int          n_total = 0;

  logic [63:0] exp_q[$];
  logic [9:0]  exp2_q[$];
  logic [9:0]  tbl2[5];

  sig_debounce_evt #(.HOLD_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .sync_sig(sync_sig), .evt_ready(evt_ready), .ovf_clr(ovf_clr),
    .stable_level(stable_level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .evt_valid(evt_valid), .evt_type(evt_type), .ovf(ovf),
    .evt_cnt(evt_cnt), .glitch_cnt(glitch_cnt)
  );

  sig_debounce_evt #(.HOLD_CYCLES(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sync_sig(sync2), .evt_ready(ready2), .ovf_clr(ovf_clr2),
    .stable_level(stable2), .rise_pulse(rise2), .fall_pulse(fall2),
    .evt_valid(valid2), .evt_type(type2), .ovf(ovf2),
    .evt_cnt(cnt2), .glitch_cnt(gl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] snap();
    return {26'b0, rise_pulse, fall_pulse, stable_level, evt_valid, evt_type, ovf, evt_cnt, glitch_cnt};
  endfunction

  function automatic logic [9:0] snap2();
    return {rise2, fall2, stable2, valid2, type2, ovf2, cnt2, gl2};
  endfunction

  function automatic logic [63:0] mk(input logic r, input logic f, input logic s, input logic v,
                                     input logic t, input logic o, input int cnt, input int gl);
    return {26'b0, r, f, s, v, t, o, 16'(cnt), 16'(gl)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sync_sig = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    sync2 = 1'b0; ready2 = 1'b0; ovf_clr2 = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (rise_pulse || fall_pulse)) begin
      if (exp_q.size() == 0) chk("sb_unexpected", snap(), 64'h0);
      else                   chk("sb_evt", snap(), exp_q.pop_front());
    end
    if (rst_n && (rise2 || fall2)) begin
      if (exp2_q.size() == 0) chk("sb2_unexpected", 64'(snap2()), 64'h0);
      else                    chk("sb2_evt", 64'(snap2()), 64'(exp2_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl2[0] = 10'b1011100100;
    tbl2[1] = 10'b0101001000;
    tbl2[2] = 10'b1011101100;
    tbl2[3] = 10'b0101001100;
    tbl2[4] = 10'b1011101100;

    rst_n = 1'b0;
    sync_sig = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    sync2 = 1'b0; ready2 = 1'b0; ovf_clr2 = 1'b0;
    tick(2);
    chk("reset_state", snap(), 64'h0);
    chk("reset_state2", 64'(snap2()), 64'h0);
    rst_n = 1'b1;

    // idle low for 100 cycles
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("idle", snap(), 64'h0);
    end

    // clean rise
    sync_sig = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 1, 0));
    tick(3);
    chk("rise_not_yet", 64'(stable_level), 64'h0);
    tick(1);
    chk("rise_accept", 64'({rise_pulse, stable_level, evt_valid, evt_type}), 64'hF);
    tick(1);
    chk("rise_pulse_end", 64'({rise_pulse, evt_valid}), 64'h1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("rise_consumed", 64'(evt_valid), 64'h0);

    // glitch: 3 cycles high then low
    do_reset();
    sync_sig = 1'b1;
    tick(3);
    sync_sig = 1'b0;
    tick(1);
    chk("glitch", snap(), mk(0, 0, 0, 0, 0, 0, 0, 1));
    tick(5);
    chk("glitch_hold", snap(), mk(0, 0, 0, 0, 0, 0, 0, 1));

    // overflow: rise then fall with no consumer
    do_reset();
    sync_sig = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 1, 0));
    tick(6);
    sync_sig = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 1, 0, 1, 2, 0));
    tick(4);
    chk("ovf_set", 64'({evt_valid, evt_type, ovf, evt_cnt}), {45'b0, 3'b101, 16'd2});
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'({evt_valid, ovf}), 64'h2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("ovf_consumed", 64'(evt_valid), 64'h0);

    // post lands on the same edge that accepts the pending rise
    do_reset();
    sync_sig = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 1, 0));
    tick(4);
    sync_sig = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 2, 0));
    tick(3);
    evt_ready = 1'b1;
    tick(1);
    chk("post_and_accept", 64'({evt_valid, evt_type, ovf}), 64'h4);
    tick(1);
    evt_ready = 1'b0;
    chk("fall_consumed", 64'(evt_valid), 64'h0);

    // 2-bit counters saturate at 3
    do_reset();
    ready2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sync2 = ~sync2;
      exp2_q.push_back(tbl2[i]);
      tick(5);
    end
    tick(5);
    chk("cnt2_saturated", 64'({cnt2, valid2}), 64'h6);

    // asynchronous reset in the middle of a rise qualification
    do_reset();
    sync_sig = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 1, 0));
    tick(4);
    sync_sig = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 1, 0, 1, 2, 0));
    tick(4);
    sync_sig = 1'b1;
    tick(2);
    chk("pre_async_rst", snap(), mk(0, 0, 0, 1, 0, 1, 2, 0));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", snap(), 64'h0);
    tick(1);
    rst_n = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 1, 0));
    tick(3);
    chk("post_rst_not_yet", 64'(stable_level), 64'h0);
    tick(1);
    chk("post_rst_rise", 64'({rise_pulse, stable_level, evt_cnt}), {46'b0, 2'b11, 16'd1});

    tick(5);
    chk("sb_drain", 64'(exp_q.size() + exp2_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
